// File: rtl/nabp_state_control_pkg.sv
// Shared definitions for the NABP shifter sequencing logic: controller state
// encoding and the default image geometry used by the shifter and address generators.
package nabp_state_control_pkg;

   localparam int unsigned NABP_NO_OF_ANGLES  = 180;
   localparam int unsigned NABP_ANGLE_WIDTH   = 8;
   localparam int unsigned NABP_TIMEOUT       = 4096;
   localparam int unsigned NABP_TIMEOUT_WIDTH = 13;

   typedef enum logic [2:0] {
      READY_S      = 3'd0,
      FILL_KICK_S  = 3'd1,
      FILL_WAIT_S  = 3'd2,
      PE_WAIT_S    = 3'd3,
      SHIFT_KICK_S = 3'd4,
      SHIFT_WAIT_S = 3'd5
   } nabp_state_e;

   // States in which the controller is blocked on an external event.
   function automatic logic is_wait_state(input nabp_state_e s);
      return (s == FILL_WAIT_S) || (s == PE_WAIT_S) || (s == SHIFT_WAIT_S);
   endfunction

endpackage

// File: rtl/nabp_state_control_watchdog.sv
// Phase watchdog: counts cycles while enabled, restarts on clear, and flags
// the cycle that completes TIMEOUT consecutive enabled cycles.
module nabp_watchdog #(
   parameter int unsigned TIMEOUT       = 4096,
   parameter int unsigned TIMEOUT_WIDTH = 13
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   logic [TIMEOUT_WIDTH-1:0] count_q, count_d;

   assign expired_o = enable_i && (count_q == TIMEOUT_WIDTH'(TIMEOUT - 1));

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + TIMEOUT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/nabp_state_control.sv
// Initiator side of the shifter fill/shift kick-done protocol: walks every
// projection angle of one image and guards each wait phase with a watchdog.
module nabp_state_control
   import nabp_state_control_pkg::*;
#(
   parameter int unsigned NO_OF_ANGLES  = NABP_NO_OF_ANGLES,
   parameter int unsigned ANGLE_WIDTH   = NABP_ANGLE_WIDTH,
   parameter int unsigned TIMEOUT       = NABP_TIMEOUT,
   parameter int unsigned TIMEOUT_WIDTH = NABP_TIMEOUT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start_kick,
   input  logic                   pe_ready,
   input  logic                   sc_fill_done,
   input  logic                   sc_shift_done,
   output logic                   sc_fill_kick,
   output logic                   sc_shift_kick,
   output logic [ANGLE_WIDTH-1:0] angle,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam logic [ANGLE_WIDTH-1:0] LAST_ANGLE = ANGLE_WIDTH'(NO_OF_ANGLES - 1);

   nabp_state_e            state_q, state_d;
   logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic                   wd_clear, wd_enable, wd_expired;

   // Every wait state is entered from a different state, so any state change
   // doubles as the watchdog restart.
   assign wd_enable = is_wait_state(state_q);
   assign wd_clear  = (state_d != state_q);

   nabp_watchdog #(
      .TIMEOUT       (TIMEOUT),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
   ) u_watchdog (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear_i   (wd_clear),
      .enable_i  (wd_enable),
      .expired_o (wd_expired)
   );

   // A done strobe or pe_ready arriving on the final watchdog cycle still
   // advances the sequence; the timeout only fires when nothing happened.
   always_comb begin
      state_d = state_q;
      angle_d = angle_q;
      done_d  = 1'b0;
      error_d = error_q;
      case (state_q)
         READY_S: begin
            if (start_kick) begin
               state_d = FILL_KICK_S;
               angle_d = '0;
               error_d = 1'b0;
            end
         end
         FILL_KICK_S: begin
            state_d = FILL_WAIT_S;
         end
         FILL_WAIT_S: begin
            if (sc_fill_done) begin
               state_d = PE_WAIT_S;
            end else if (wd_expired) begin
               state_d = READY_S;
               error_d = 1'b1;
            end
         end
         PE_WAIT_S: begin
            if (pe_ready) begin
               state_d = SHIFT_KICK_S;
            end else if (wd_expired) begin
               state_d = READY_S;
               error_d = 1'b1;
            end
         end
         SHIFT_KICK_S: begin
            state_d = SHIFT_WAIT_S;
         end
         SHIFT_WAIT_S: begin
            if (sc_shift_done) begin
               if (angle_q == LAST_ANGLE) begin
                  state_d = READY_S;
                  done_d  = 1'b1;
               end else begin
                  state_d = FILL_KICK_S;
                  angle_d = angle_q + ANGLE_WIDTH'(1);
               end
            end else if (wd_expired) begin
               state_d = READY_S;
               error_d = 1'b1;
            end
         end
         default: begin
            state_d = READY_S;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= READY_S;
         angle_q <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         angle_q <= angle_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign sc_fill_kick  = (state_q == FILL_KICK_S);
   assign sc_shift_kick = (state_q == SHIFT_KICK_S);
   assign angle         = angle_q;
   assign busy          = (state_q != READY_S);
   assign done          = done_q;
   assign error         = error_q;

endmodule

// File: tb/tb_nabp_state_control.sv
// Directed bench for nabp_state_control: three instances cover the 3-angle
// flow, a short watchdog, and the single-angle image.
`timescale 1ns/1ps
module tb_nabp_state_control;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   // dut_a: 3 angles, TIMEOUT 32
   logic a_start = 0, a_pe_ready = 0, a_fill_done = 0, a_shift_done = 0;
   logic a_fill_kick, a_shift_kick, a_busy, a_done, a_error;
   logic [1:0] a_angle;
   // dut_t: 3 angles, TIMEOUT 16
   logic t_start = 0, t_pe_ready = 0, t_fill_done = 0, t_shift_done = 0;
   logic t_fill_kick, t_shift_kick, t_busy, t_done, t_error;
   logic [1:0] t_angle;
   // dut_o: 1 angle, TIMEOUT 16
   logic o_start = 0, o_pe_ready = 0, o_fill_done = 0, o_shift_done = 0;
   logic o_fill_kick, o_shift_kick, o_busy, o_done, o_error;
   logic [1:0] o_angle;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nabp_state_control #(.NO_OF_ANGLES(3), .ANGLE_WIDTH(2), .TIMEOUT(32), .TIMEOUT_WIDTH(6)) dut_a (
      .clk(clk), .reset_n(reset_n), .start_kick(a_start), .pe_ready(a_pe_ready),
      .sc_fill_done(a_fill_done), .sc_shift_done(a_shift_done),
      .sc_fill_kick(a_fill_kick), .sc_shift_kick(a_shift_kick), .angle(a_angle),
      .busy(a_busy), .done(a_done), .error(a_error));

   nabp_state_control #(.NO_OF_ANGLES(3), .ANGLE_WIDTH(2), .TIMEOUT(16), .TIMEOUT_WIDTH(5)) dut_t (
      .clk(clk), .reset_n(reset_n), .start_kick(t_start), .pe_ready(t_pe_ready),
      .sc_fill_done(t_fill_done), .sc_shift_done(t_shift_done),
      .sc_fill_kick(t_fill_kick), .sc_shift_kick(t_shift_kick), .angle(t_angle),
      .busy(t_busy), .done(t_done), .error(t_error));

   nabp_state_control #(.NO_OF_ANGLES(1), .ANGLE_WIDTH(2), .TIMEOUT(16), .TIMEOUT_WIDTH(5)) dut_o (
      .clk(clk), .reset_n(reset_n), .start_kick(o_start), .pe_ready(o_pe_ready),
      .sc_fill_done(o_fill_done), .sc_shift_done(o_shift_done),
      .sc_fill_kick(o_fill_kick), .sc_shift_kick(o_shift_kick), .angle(o_angle),
      .busy(o_busy), .done(o_done), .error(o_error));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      a_start = 0; a_pe_ready = 0; a_fill_done = 0; a_shift_done = 0;
      t_start = 0; t_pe_ready = 0; t_fill_done = 0; t_shift_done = 0;
      o_start = 0; o_pe_ready = 0; o_fill_done = 0; o_shift_done = 0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({a_fill_kick, a_shift_kick, a_angle, a_busy, a_done, a_error} !== 7'b0) begin
         failures++;
         $display("FAIL reset_dut_a: got %b want 0000000", {a_fill_kick, a_shift_kick, a_angle, a_busy, a_done, a_error});
      end
      checks++;
      if ({t_fill_kick, t_shift_kick, t_angle, t_busy, t_done, t_error} !== 7'b0) begin
         failures++;
         $display("FAIL reset_dut_t: got %b want 0000000", {t_fill_kick, t_shift_kick, t_angle, t_busy, t_done, t_error});
      end
      step();
      checks++;
      if ({o_fill_kick, o_shift_kick, o_angle, o_busy, o_done, o_error} !== 7'b0) begin
         failures++;
         $display("FAIL reset_dut_o: got %b want 0000000", {o_fill_kick, o_shift_kick, o_angle, o_busy, o_done, o_error});
      end
   endtask

   // Full pass on dut_a with a shifter model: fill_done 5 cycles after kick,
   // shift_done 8 cycles after kick; start_kick is in cycle 0.
   task automatic run_pass_a(input string tag);
      int nfill, nshift, ndone, fill_t, shift_t, fd_cyc, sd_cyc, done_cyc;
      logic [1:0] ang [3];
      nfill = 0; nshift = 0; ndone = 0; fill_t = 0; shift_t = 0;
      fd_cyc = -100; sd_cyc = -100; done_cyc = -1;
      ang[0] = 'x; ang[1] = 'x; ang[2] = 'x;
      a_pe_ready = 1'b1;
      a_start = 1'b1;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         step();
         a_start = 0; a_fill_done = 0; a_shift_done = 0;
         if (fill_t > 0) begin
            fill_t--;
            if (fill_t == 0) begin a_fill_done = 1; fd_cyc = cyc; end
         end
         if (shift_t > 0) begin
            shift_t--;
            if (shift_t == 0) begin a_shift_done = 1; sd_cyc = cyc; end
         end
         if (a_fill_kick) begin
            checks++;
            if (cyc != ((nfill == 0) ? 1 : sd_cyc + 1)) begin
               failures++;
               $display("FAIL %s_fill_kick_latency: kick %0d at cycle %0d want %0d", tag, nfill, cyc, (nfill == 0) ? 1 : sd_cyc + 1);
            end
            if (nfill < 3) ang[nfill] = a_angle;
            nfill++;
            fill_t = 5;
         end
         if (a_shift_kick) begin
            checks++;
            if (cyc != fd_cyc + 2 || a_angle !== 2'(nfill - 1)) begin
               failures++;
               $display("FAIL %s_shift_kick: cycle %0d angle %0d want cycle %0d angle %0d", tag, cyc, a_angle, fd_cyc + 2, nfill - 1);
            end
            nshift++;
            shift_t = 8;
         end
         if (a_done) begin
            ndone++;
            done_cyc = cyc;
            checks++;
            if (a_busy !== 1'b0) begin
               failures++;
               $display("FAIL %s_busy_at_done: got %b want 0", tag, a_busy);
            end
         end
      end
      checks++;
      if (nfill != 3 || nshift != 3) begin
         failures++;
         $display("FAIL %s_kick_counts: fill=%0d shift=%0d want 3/3", tag, nfill, nshift);
      end
      checks++;
      if (ang[0] !== 2'd0 || ang[1] !== 2'd1 || ang[2] !== 2'd2) begin
         failures++;
         $display("FAIL %s_angle_seq: got %0d,%0d,%0d want 0,1,2", tag, ang[0], ang[1], ang[2]);
      end
      checks++;
      if (ndone != 1 || done_cyc != sd_cyc + 1 || done_cyc != 49) begin
         failures++;
         $display("FAIL %s_done: count=%0d cycle=%0d want count=1 cycle=49", tag, ndone, done_cyc);
      end
      checks++;
      if (a_busy !== 1'b0 || a_error !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle_after: busy=%b error=%b want 0/0", tag, a_busy, a_error);
      end
   endtask

   task automatic test_full_pass();
      do_reset();
      run_pass_a("pass");
   endtask

   task automatic test_pe_backpressure();
      int early;
      early = 0;
      do_reset();
      a_pe_ready = 1'b0;
      a_start = 1'b1;
      step();                       // cycle 1
      a_start = 0;
      checks++;
      if (a_fill_kick !== 1'b1) begin
         failures++;
         $display("FAIL pe_fill_kick: got %b want 1", a_fill_kick);
      end
      step(); step();               // cycle 3
      a_fill_done = 1;
      for (int i = 1; i <= 20; i++) begin
         step();                    // cycles 4..23, pe_ready low
         a_fill_done = 0;
         if (a_shift_kick !== 1'b0) early++;
      end
      step();                       // cycle 24
      if (a_shift_kick !== 1'b0) early++;
      checks++;
      if (early != 0) begin
         failures++;
         $display("FAIL pe_early_shift_kick: got %0d kicks want 0", early);
      end
      a_pe_ready = 1'b1;
      step();                       // cycle 25
      checks++;
      if (a_shift_kick !== 1'b1 || a_error !== 1'b0) begin
         failures++;
         $display("FAIL pe_shift_kick: kick=%b error=%b want 1/0", a_shift_kick, a_error);
      end
   endtask

   task automatic test_spurious();
      do_reset();
      a_pe_ready = 1'b1;
      a_fill_done = 1;              // idle, must be ignored
      step();
      a_fill_done = 0;
      checks++;
      if (a_busy !== 1'b0 || a_fill_kick !== 1'b0 || a_shift_kick !== 1'b0) begin
         failures++;
         $display("FAIL spur_idle_fill_done: busy=%b fk=%b sk=%b want 000", a_busy, a_fill_kick, a_shift_kick);
      end
      a_start = 1;                  // cycle 0
      step();                       // cycle 1
      a_start = 0;
      step();                       // cycle 2, fill_wait
      a_shift_done = 1;
      step();                       // cycle 3
      a_shift_done = 0;
      checks++;
      if (a_busy !== 1'b1 || a_fill_kick !== 1'b0 || a_shift_kick !== 1'b0) begin
         failures++;
         $display("FAIL spur_shift_in_fill_wait: busy=%b fk=%b sk=%b want 100", a_busy, a_fill_kick, a_shift_kick);
      end
      step();                       // cycle 4
      a_fill_done = 1;
      a_shift_done = 1;
      step();                       // cycle 5, pe_wait
      a_fill_done = 0;
      a_shift_done = 0;
      checks++;
      if (a_fill_kick !== 1'b0 || a_shift_kick !== 1'b0) begin
         failures++;
         $display("FAIL spur_both_pe_wait: fk=%b sk=%b want 00", a_fill_kick, a_shift_kick);
      end
      step();                       // cycle 6
      checks++;
      if (a_shift_kick !== 1'b1 || a_angle !== 2'd0) begin
         failures++;
         $display("FAIL spur_both_shift_kick: sk=%b angle=%0d want 1/0", a_shift_kick, a_angle);
      end
      step();                       // cycle 7, shift_wait
      a_start = 1;
      step();                       // cycle 8
      a_start = 0;
      checks++;
      if (a_fill_kick !== 1'b0 || a_busy !== 1'b1 || a_angle !== 2'd0) begin
         failures++;
         $display("FAIL spur_start_busy: fk=%b busy=%b angle=%0d want 0/1/0", a_fill_kick, a_busy, a_angle);
      end
      step();                       // cycle 9
      a_shift_done = 1;
      step();                       // cycle 10
      a_shift_done = 0;
      checks++;
      if (a_fill_kick !== 1'b1 || a_angle !== 2'd1) begin
         failures++;
         $display("FAIL spur_next_angle: fk=%b angle=%0d want 1/1", a_fill_kick, a_angle);
      end
   endtask

   task automatic test_timeout();
      int bad, seen_done;
      bad = 0; seen_done = 0;
      do_reset();
      t_pe_ready = 1'b1;
      t_start = 1;                  // cycle 0
      for (int cyc = 1; cyc <= 17; cyc++) begin
         step();
         t_start = 0;
         t_fill_done = (cyc == 6);
         t_shift_done = (cyc == 16);
         if (t_done) seen_done++;
      end
      checks++;
      if (t_fill_kick !== 1'b1 || t_angle !== 2'd1) begin
         failures++;
         $display("FAIL to_second_fill: fk=%b angle=%0d want 1/1", t_fill_kick, t_angle);
      end
      for (int cyc = 18; cyc <= 33; cyc++) begin
         step();                    // 16 fill_wait cycles, no fill_done
         if (t_error !== 1'b0 || t_busy !== 1'b1) bad++;
         if (t_done) seen_done++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL to_early_error: %0d bad cycles want 0", bad);
      end
      step();                       // cycle 34
      checks++;
      if (t_error !== 1'b1 || t_busy !== 1'b0 || t_angle !== 2'd1) begin
         failures++;
         $display("FAIL to_expire: error=%b busy=%b angle=%0d want 1/0/1", t_error, t_busy, t_angle);
      end
      repeat (5) begin
         step();
         if (t_done) seen_done++;
      end
      checks++;
      if (t_error !== 1'b1 || seen_done != 0) begin
         failures++;
         $display("FAIL to_sticky: error=%b done_pulses=%0d want 1/0", t_error, seen_done);
      end
      t_start = 1;
      step();
      t_start = 0;
      checks++;
      if (t_error !== 1'b0 || t_fill_kick !== 1'b1 || t_angle !== 2'd0) begin
         failures++;
         $display("FAIL to_restart: error=%b fk=%b angle=%0d want 0/1/0", t_error, t_fill_kick, t_angle);
      end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      a_pe_ready = 1'b1;
      a_start = 1;                  // cycle 0
      for (int cyc = 1; cyc <= 28; cyc++) begin
         step();
         a_start = 0;
         a_fill_done = (cyc == 6) || (cyc == 22);
         a_shift_done = (cyc == 16);
      end
      checks++;
      if (a_busy !== 1'b1 || a_angle !== 2'd1) begin
         failures++;
         $display("FAIL mid_precondition: busy=%b angle=%0d want 1/1", a_busy, a_angle);
      end
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if ({a_fill_kick, a_shift_kick, a_angle, a_busy, a_done, a_error} !== 7'b0) begin
         failures++;
         $display("FAIL mid_async_reset: got %b want 0000000", {a_fill_kick, a_shift_kick, a_angle, a_busy, a_done, a_error});
      end
      a_fill_done = 0; a_shift_done = 0;
      step();
      step();
      reset_n = 1'b1;
      run_pass_a("post_reset");
   endtask

   task automatic test_single_angle();
      int nfill, nshift, ndone, done_cyc, bad_angle;
      nfill = 0; nshift = 0; ndone = 0; done_cyc = -1; bad_angle = 0;
      do_reset();
      o_pe_ready = 1'b1;
      o_start = 1;                  // cycle 0
      for (int cyc = 1; cyc <= 30; cyc++) begin
         step();
         o_start = 0;
         o_fill_done = (cyc == 6);
         o_shift_done = (cyc == 16);
         if (o_fill_kick) nfill++;
         if (o_shift_kick) nshift++;
         if (o_done) begin ndone++; done_cyc = cyc; end
         if (o_angle !== 2'd0) bad_angle++;
      end
      checks++;
      if (nfill != 1 || nshift != 1) begin
         failures++;
         $display("FAIL single_kicks: fill=%0d shift=%0d want 1/1", nfill, nshift);
      end
      checks++;
      if (ndone != 1 || done_cyc != 17) begin
         failures++;
         $display("FAIL single_done: count=%0d cycle=%0d want 1/17", ndone, done_cyc);
      end
      checks++;
      if (bad_angle != 0 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL single_angle_idle: nonzero_angle_cycles=%0d busy=%b want 0/0", bad_angle, o_busy);
      end
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_pe_backpressure();
      test_spurious();
      test_timeout();
      test_reset_mid_op();
      test_single_angle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation still running at %0t want finished", $time);
      $fatal(1);
   end

endmodule

// File: doc/nabp_state_control.md
Name: nabp_state_control

Overview:
- Initiator side of the fill/shift kick-done protocol: the controller that sequences the shifter.
- Steps through all projection angles of one image. For each angle it kicks a fill, waits for fill done, waits for the processing elements to be ready, kicks a shift, then waits for shift done.
- Sits between the top-level start/done handshake and the shifter/filter mapper. It publishes the current angle index to downstream address logic.
- Includes a per-phase watchdog so a lost done is flagged rather than hanging the pipeline.

Parameters:
- NO_OF_ANGLES, 180, projection angles per image; must be >= 1.
- ANGLE_WIDTH, 8, width of the angle index; requires 2^ANGLE_WIDTH >= NO_OF_ANGLES.
- TIMEOUT, 4096, maximum cycles spent in any wait phase before an error is raised; must be >= 1.
- TIMEOUT_WIDTH, 13, width of the watchdog counter; requires 2^TIMEOUT_WIDTH > TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_kick  in  1  one-cycle pulse that begins an image; ignored unless in ready_s.
- pe_ready  in  1  level; processing elements can accept a shift pass.
- sc_fill_done  in  1  shifter fill-complete strobe.
- sc_shift_done  in  1  shifter shift-complete strobe.
- sc_fill_kick  out  1  registered one-cycle pulse to the shifter.
- sc_shift_kick  out  1  registered one-cycle pulse to the shifter.
- angle  out  ANGLE_WIDTH  index of the angle currently being processed.
- busy  out  1  high in every state except ready_s.
- done  out  1  registered one-cycle pulse when the last angle's shift completes.
- error  out  1  sticky watchdog flag; cleared only by reset or by the next accepted start_kick.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the next clk edge):
  - state = ready_s, angle = 0, watchdog = 0.
  - All outputs = 0.
- States and transitions:
  - ready_s: on start_kick go to fill_kick_s, set angle = 0, clear error.
  - fill_kick_s: assert sc_fill_kick for exactly this one cycle, then go to fill_wait_s.
  - fill_wait_s: on sc_fill_done go to pe_wait_s.
  - pe_wait_s: when pe_ready = 1 go to shift_kick_s. pe_ready already high on entry still costs this one cycle.
  - shift_kick_s: assert sc_shift_kick for one cycle, then go to shift_wait_s.
  - shift_wait_s: on sc_shift_done:
    - if angle == NO_OF_ANGLES-1: pulse done, go to ready_s.
    - otherwise: angle <= angle+1, go to fill_kick_s.
- Kick outputs are Moore-decoded from the registered state, so each kick is high for exactly one cycle and never in consecutive cycles.
- Latency:
  - start_kick at cycle 0 gives sc_fill_kick high at cycle 1.
  - sc_fill_done at cycle n with pe_ready already high gives sc_shift_kick at cycle n+2.
  - sc_shift_done at cycle m on a non-final angle gives the next sc_fill_kick at cycle m+1.
- Done strobes:
  - Sampled only in their matching wait state; a strobe arriving in any other state is ignored.
  - sc_fill_done and sc_shift_done both high in fill_wait_s: only the fill done is acted on.
- Watchdog:
  - Cleared on entry to fill_wait_s, pe_wait_s and shift_wait_s; increments each cycle spent in those states.
  - On reaching TIMEOUT: error <= 1 and state <= ready_s. No done pulse is issued; angle holds its value for debug.
- start_kick while busy is ignored; it does not restart the sequence.
- angle is stable from its fill_kick_s through its shift_wait_s exit, never exceeds NO_OF_ANGLES-1, and does not wrap.
- NO_OF_ANGLES = 1: a single fill/shift pass, then done.
- Reset mid-operation: returns to ready_s immediately; any kick pulse in flight is cut off.

Decomposition:
- Shared package:
  - state encoding for ready_s, fill_kick_s, fill_wait_s, pe_wait_s, shift_kick_s, shift_wait_s;
  - NO_OF_ANGLES, ANGLE_WIDTH and TIMEOUT defaults, so the shifter and address generators use the same values.
- One natural sub-module, nabp_watchdog: counter with clear/enable inputs and an expired output.
- FSM and angle counter stay in the top module.

Test Plan:
- NO_OF_ANGLES=3, pe_ready tied 1, shifter model returns fill_done 5 cycles after kick and shift_done 8 cycles after kick:
  - exactly 3 fill kicks and 3 shift kicks;
  - angle sequence 0,1,2;
  - done pulses once, one cycle after the third shift_done; busy then drops.
- pe_ready held 0 for 20 cycles after fill_done: sc_shift_kick rises exactly 1 cycle after pe_ready rises, and no earlier.
- Spurious strobes: sc_shift_done during fill_wait_s and sc_fill_done during ready_s produce no state change. start_kick during shift_wait_s is ignored and angle is unchanged.
- TIMEOUT=16, shifter never returns fill_done:
  - error set at the 16th wait cycle; state returns to ready_s, busy=0, done never pulses;
  - the next start_kick clears error and restarts at angle 0.
- reset_n pulsed low mid-shift_wait_s at angle 1: all outputs 0 and angle=0 immediately (asynchronously); a subsequent start_kick runs a full 3-angle pass cleanly.
- NO_OF_ANGLES=1: a single fill/shift pair, done asserted, angle stays 0 throughout.
